// File: rtl/multi_range_finder.sv
// Per-channel running min/max tracker reporting max-min and a saturating sample count.
// Define MULTI_RANGE_FINDER_SIGNED_EN for two's-complement sample comparison.
module multi_range_finder #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      go,
  input  logic                      finish,
  input  logic                      data_valid,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS*WIDTH-1:0] range,
  output logic                      result_valid,
  output logic [CNT_WIDTH-1:0]      sample_count,
  output logic                      busy,
  output logic                      error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

`ifdef MULTI_RANGE_FINDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_INIT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_INIT = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic lt(input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
    return $signed(a) < $signed(b);
  endfunction
`else
  localparam logic [WIDTH-1:0] MIN_INIT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_INIT = {WIDTH{1'b0}};

  function automatic logic lt(input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
    return a < b;
  endfunction
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]     min_q [CHANNELS];
  logic [WIDTH-1:0]     min_d [CHANNELS];
  logic [WIDTH-1:0]     max_q [CHANNELS];
  logic [WIDTH-1:0]     max_d [CHANNELS];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    for (int k = 0; k < CHANNELS; k++) begin
      min_d[k] = min_q[k];
      max_d[k] = max_q[k];
    end
    unique case (state_q)
      S_IDLE: begin
        if (go && !finish) begin
          state_d = S_RUN;
          count_d = CNT_ONE;
          for (int k = 0; k < CHANNELS; k++) begin
            min_d[k] = data_in[k*WIDTH +: WIDTH];
            max_d[k] = data_in[k*WIDTH +: WIDTH];
          end
        end else if (!go && finish) begin
          state_d = S_ERR;
        end
      end
      S_RUN: begin
        if (data_valid) begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (lt(data_in[k*WIDTH +: WIDTH], min_q[k]))
              min_d[k] = data_in[k*WIDTH +: WIDTH];
            if (lt(max_q[k], data_in[k*WIDTH +: WIDTH]))
              max_d[k] = data_in[k*WIDTH +: WIDTH];
          end
          if (count_q != {CNT_WIDTH{1'b1}})
            count_d = count_q + CNT_ONE;
        end
        if (finish)
          state_d = S_DONE;
      end
      S_DONE: begin
        if (!finish)
          state_d = S_IDLE;
      end
      S_ERR: begin
        if (go && !finish)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        min_q[k] <= MIN_INIT;
        max_q[k] <= MAX_INIT;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int k = 0; k < CHANNELS; k++) begin
        min_q[k] <= min_d[k];
        max_q[k] <= max_d[k];
      end
    end
  end

  // Outputs are gated by reset so they read zero while it is held.
  always_comb begin
    result_valid = !reset && (state_q == S_DONE);
    busy         = !reset && (state_q == S_RUN);
    error        = 1'b0;
    range        = '0;
    sample_count = '0;
    if (!reset) begin
      if (state_q == S_IDLE)
        error = go && finish;
      else if (state_q == S_ERR)
        error = !(go && !finish);
    end
    if (result_valid) begin
      for (int k = 0; k < CHANNELS; k++)
        range[k*WIDTH +: WIDTH] = max_q[k] - min_q[k];
      sample_count = count_q;
    end
  end

endmodule

// File: tb/tb_multi_range_finder.sv
// Directed bench for multi_range_finder (WIDTH=16, CHANNELS=2, CNT_WIDTH=8).
module tb_multi_range_finder;

  logic        clock = 1'b0;
  logic        reset;
  logic        go;
  logic        finish;
  logic        data_valid;
  logic [31:0] data_in;
  logic [31:0] range;
  logic        result_valid;
  logic [7:0]  sample_count;
  logic        busy;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  multi_range_finder #(
    .WIDTH(16), .CHANNELS(2), .CNT_WIDTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .go(go),
    .finish(finish),
    .data_valid(data_valid),
    .data_in(data_in),
    .range(range),
    .result_valid(result_valid),
    .sample_count(sample_count),
    .busy(busy),
    .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic g, input logic f, input logic v,
                       input logic [15:0] c1, input logic [15:0] c0);
    go = g;
    finish = f;
    data_valid = v;
    data_in = {c1, c0};
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_range", range, 32'd0);
    check("rst_cnt", 32'(sample_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    reset = 1'b0;
    step();

    // basic run
    drive(1'b1, 1'b0, 1'b0, 16'd5, 16'd100);
    check("idle_busy", 32'(busy), 32'd0);
    step();
    check("run_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 16'd5, 16'd40);
    step();
    drive(1'b0, 1'b1, 1'b1, 16'd5, 16'd300);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    check("basic_rv", 32'(result_valid), 32'd1);
    check("basic_r0", 32'(range[15:0]), 32'd260);
    check("basic_r1", 32'(range[31:16]), 32'd0);
    check("basic_cnt", 32'(sample_count), 32'd3);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_err", 32'(error), 32'd0);
    step();
    check("back_idle_rv", 32'(result_valid), 32'd0);
    check("back_idle_rng", range, 32'd0);
    check("back_idle_cnt", 32'(sample_count), 32'd0);

    // go & finish in IDLE
    drive(1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
    check("gf_err", 32'(error), 32'd1);
    check("gf_busy", 32'(busy), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    check("gf_err_clr", 32'(error), 32'd0);
    check("gf_busy2", 32'(busy), 32'd0);
    step();
    check("gf_still_idle", 32'(busy), 32'd0);

    // finish without go -> ERROR
    drive(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("err_hold", 32'(error), 32'd1);
      check("err_busy", 32'(busy), 32'd0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    check("err_exit", 32'(error), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    check("err_idle", 32'(error), 32'd0);
    check("err_idle_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd1, 16'd10);
    step();
    check("clean_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 16'd99, 16'd99);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    check("clean_rv", 32'(result_valid), 32'd1);
    check("clean_rng", range, 32'd0);
    check("clean_cnt", 32'(sample_count), 32'd1);
    step();

    // saturation and ignored invalid samples
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd1000);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'(i % 7), 16'(1000 + i % 50));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    check("sat_busy", 32'(busy), 32'd1);
    step();
    step();
    drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    step();
    drive(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    check("sat_rv", 32'(result_valid), 32'd1);
    check("sat_cnt", 32'(sample_count), 32'd255);
    check("sat_r0", 32'(range[15:0]), 32'd49);
    check("sat_r1", 32'(range[31:16]), 32'd6);
    step();
    check("done_hold", 32'(result_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    step();
    check("done_exit", 32'(result_valid), 32'd0);

    // async reset mid-run
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd50);
    step();
    drive(1'b0, 1'b0, 1'b1, 16'd9, 16'd60);
    step();
    drive(1'b0, 1'b0, 1'b1, 16'd3, 16'd70);
    step();
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rv", 32'(result_valid), 32'd0);
    check("arst_err", 32'(error), 32'd0);
    check("arst_rng", range, 32'd0);
    check("arst_cnt", 32'(sample_count), 32'd0);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd7);
    step();
    drive(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    check("post_rst_rv", 32'(result_valid), 32'd1);
    check("post_rst_r0", 32'(range[15:0]), 32'd0);
    check("post_rst_cnt", 32'(sample_count), 32'd1);
    step();

    // signed vs unsigned compare
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'hFFFE);
    step();
    drive(1'b0, 1'b1, 1'b1, 16'd0, 16'h0003);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
`ifdef MULTI_RANGE_FINDER_SIGNED_EN
    check("sign_r0", 32'(range[15:0]), 32'd5);
`else
    check("sign_r0", 32'(range[15:0]), 32'hFFFB);
`endif
    check("sign_cnt", 32'(sample_count), 32'd2);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
